axis_sample_combiner: RTL
=========================

# axis_sample_combiner

N-channel AXI-Stream sample combiner: joins one beat from each enabled input channel, sums the signed samples lane by lane, then scales, rounds and saturates the sum back to sample width. It sits after the per-channel beamforming weights and feeds the downstream DMA/packetiser. It generalises the fixed four-channel adder in four ways: parametrised channel count, a proper valid/ready join, a selectable rounding mode, and saturation with statistics. It sustains one beat per cycle.

## Interface
- NUM_CH, 4: number of input channels, 2..8.
- SAMPLE_WIDTH, 16: signed two's-complement sample width, input and output.
- SAMPLES, 16: samples per beat.
- SHIFT, 2: arithmetic right shift applied to the sum, 0..clog2(NUM_CH).
- ROUND_MODE, 1: 0 = truncate (floor), 1 = round half up.
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- ch_enable  in  NUM_CH  per-channel enable, sampled on every cycle.
- clear  in  1  synchronous clear of sat_count and tlast_mismatch.
- s_axis_tdata  in  NUM_CH*SAMPLES*SAMPLE_WIDTH  channel c occupies bits [c*SAMPLES*SAMPLE_WIDTH +: SAMPLES*SAMPLE_WIDTH]; sample i of a channel occupies [i*SAMPLE_WIDTH +: SAMPLE_WIDTH].
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tlast  in  NUM_CH  per-channel last.
- s_axis_tready  out  NUM_CH  per-channel ready.
- m_axis_tdata  out  SAMPLES*SAMPLE_WIDTH  combined samples, same lane layout as the inputs.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output last.
- m_axis_tready  in  1  downstream ready.
- sat_count  out  16  number of output beats containing at least one saturated sample. Holds at 0xFFFF once reached.
- tlast_mismatch  out  1  sticky; set when the tlast bits of the enabled channels in a joined beat disagree.

## Operation
- **Join.** A beat fires when all of the following hold:
  - at least one channel is enabled;
  - every enabled channel has tvalid=1;
  - stage 1 can accept (stage 1 empty, or stage 1 advancing this cycle).
- **Ready.** s_axis_tready[c] = fire & ch_enable[c]. All enabled channels are consumed in the same cycle. Disabled channels see tready=0 and contribute zero to the sum.
- **Stage 1 (sum).** Per lane, sign-extend each enabled sample to SAMPLE_WIDTH+clog2(NUM_CH) bits and add. The sum cannot overflow at this width. The stage also registers tlast_out = OR of the enabled tlast bits, plus the mismatch flag.
- **Stage 2 (scale).**
  - If ROUND_MODE=1 and SHIFT>0, add 2^(SHIFT-1) to the sum.
  - Arithmetic shift right by SHIFT.
  - Saturate to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
  - Any clipped lane marks the beat as saturated.
- **Output.** The stage-2 register drives m_axis_*.
- **Stall rule.**
  - Stage 2 loads when it is empty or m_axis_tready=1.
  - Stage 1 loads when it is empty or stage 2 is loading.
  - Contents are held while stalled. Data must not be lost or duplicated.
- **Statistics.**
  - sat_count increments by 1 when a saturated beat is loaded into stage 2; it saturates at 0xFFFF.
  - tlast_mismatch sets when a mismatched beat fires.
  - clear=1 zeroes both outputs. If clear and an increment occur in the same cycle, clear wins.
- **ch_enable changes** affect only beats that have not yet fired. Beats already in the pipeline complete unchanged.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, s_axis_tready=0, sat_count=0, tlast_mismatch=0. Both stage valids are cleared.
- Reset mid-operation drops in-flight beats; no partial beat is emitted afterwards.
- Latency: an input fired at cycle N appears on m_axis at N+2 (valid from the rising edge ending cycle N+1) when there is no backpressure.
- Throughput: 1 beat/cycle with m_axis_tready held high.
- s_axis_tready depends combinationally on s_axis_tvalid, ch_enable, m_axis_tready and the internal valids. There is no combinational path from any tdata.
- m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 and m_axis_tready=0.
- With ch_enable=0: no fire, all tready=0, the pipeline drains normally.

## Test plan
- **Basic sum**, default parameters. All 4 channels send every lane = 100 → output lanes = 100 (sum 400 >> 2). Latency 2 cycles.
- **Rounding.** Lanes 1,1,1,0 (sum 3):
  - ROUND_MODE=1 → output 1;
  - ROUND_MODE=0 → output 0.
  - Lanes -1,-1,-1,0 (sum -3): round → -1; truncate → -1.
- **Saturation**, SHIFT=0. All lanes 0x7FFF on 4 channels → output 0x7FFF and sat_count=1. All lanes 0x8000 → output 0x8000 and sat_count=2. Pulse clear → sat_count=0.
- **Join/backpressure.**
  - Channel 2 withholds tvalid for 3 cycles → no tready on any channel and no output.
  - Toggle m_axis_tready randomly over 1000 random beats → output matches the reference-model sequence exactly, with no drops or duplicates.
- **Channel masking.** ch_enable=4'b0011; channels 0,1 send 200, channels 2,3 send 0x7FFF with tvalid=0 → output 100. Channels 2,3 see tready=0 throughout.
- **tlast and reset.**
  - Enabled tlasts 1,0,1,1 → m_axis_tlast=1 and tlast_mismatch=1.
  - Assert reset with 2 beats in flight → m_axis_tvalid=0 on the next cycle, and no stale beat appears after reset is released.

Source files
------------

// File: rtl/axis_sample_combiner.sv
// rtl/axis_sample_combiner.sv - N-channel AXI-Stream sample combiner (join, sum, scale, round, saturate)
// Two register stages: stage 1 holds the widened lane sums, stage 2 drives m_axis_*.
module axis_sample_combiner #(
  parameter int NUM_CH       = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int SAMPLES      = 16,
  parameter int SHIFT        = 2,
  parameter int ROUND_MODE   = 1
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_CH-1:0]                       ch_enable,
  input  logic                                    clear,
  input  logic [NUM_CH*SAMPLES*SAMPLE_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_CH-1:0]                       s_axis_tvalid,
  input  logic [NUM_CH-1:0]                       s_axis_tlast,
  output logic [NUM_CH-1:0]                       s_axis_tready,
  output logic [SAMPLES*SAMPLE_WIDTH-1:0]         m_axis_tdata,
  output logic                                    m_axis_tvalid,
  output logic                                    m_axis_tlast,
  input  logic                                    m_axis_tready,
  output logic [15:0]                             sat_count,
  output logic                                    tlast_mismatch
);

  localparam int SW   = SAMPLE_WIDTH;
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SUMW = SW + CW;
  localparam int W2   = SUMW + 1;
  localparam int BW   = SAMPLES * SW;
  localparam int RND  = (ROUND_MODE == 1) ? ((1 << SHIFT) >> 1) : 0;
  localparam logic signed [W2-1:0] MAXV = {{(W2-SW+1){1'b0}}, {(SW-1){1'b1}}};
  localparam logic signed [W2-1:0] MINV = {{(W2-SW+1){1'b1}}, {(SW-1){1'b0}}};

  logic                    s1_valid, s2_valid, s1_last;
  logic [SAMPLES*SUMW-1:0] s1_sum, sum_next;
  logic [BW-1:0]           scaled;
  logic                    sat_any, fire, s1_ready, s2_load, all_valid;
  logic                    last_next, mismatch_next;
  logic [NUM_CH-1:0]       last_en;
  logic signed [SUMW-1:0]  acc;
  logic signed [W2-1:0]    lane_ext, lane_sh;

  assign s2_load       = !s2_valid || m_axis_tready;
  assign s1_ready      = !s1_valid || s2_load;
  assign all_valid     = &(s_axis_tvalid | ~ch_enable);
  assign fire          = !reset && (|ch_enable) && all_valid && s1_ready;
  assign s_axis_tready = fire ? ch_enable : '0;
  assign last_en       = s_axis_tlast & ch_enable;
  assign last_next     = |last_en;
  assign mismatch_next = last_next && (last_en != ch_enable);
  assign m_axis_tvalid = s2_valid;

  // Disabled channels contribute zero; the widened sum cannot overflow.
  always_comb begin
    sum_next = '0;
    acc      = '0;
    for (int i = 0; i < SAMPLES; i++) begin
      acc = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_enable[c]) begin
          acc = acc + SUMW'($signed(s_axis_tdata[c*BW + i*SW +: SW]));
        end
      end
      sum_next[i*SUMW +: SUMW] = acc;
    end
  end

  // One extra bit of headroom keeps the rounding offset from wrapping.
  always_comb begin
    scaled   = '0;
    sat_any  = 1'b0;
    lane_ext = '0;
    lane_sh  = '0;
    for (int i = 0; i < SAMPLES; i++) begin
      lane_ext = W2'($signed(s1_sum[i*SUMW +: SUMW])) + W2'(RND);
      lane_sh  = lane_ext >>> SHIFT;
      if (lane_sh > MAXV) begin
        scaled[i*SW +: SW] = {1'b0, {(SW-1){1'b1}}};
        sat_any = 1'b1;
      end else if (lane_sh < MINV) begin
        scaled[i*SW +: SW] = {1'b1, {(SW-1){1'b0}}};
        sat_any = 1'b1;
      end else begin
        scaled[i*SW +: SW] = lane_sh[SW-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_last       <= 1'b0;
      s1_sum        <= '0;
      s2_valid      <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid <= fire;
        if (fire) begin
          s1_sum  <= sum_next;
          s1_last <= last_next;
        end
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          m_axis_tdata <= scaled;
          m_axis_tlast <= s1_last;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      sat_count      <= '0;
      tlast_mismatch <= 1'b0;
    end else begin
      if (s2_load && s1_valid && sat_any && sat_count != 16'hFFFF) begin
        sat_count <= sat_count + 16'd1;
      end
      if (fire && mismatch_next) begin
        tlast_mismatch <= 1'b1;
      end
    end
  end

endmodule
